// File: rtl/wisard_pkg.sv
// ============================================================================
// Module      : wisard_pkg
// Description : Shared FSM encoding and sizing helper for the WiSARD stream TX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wisard_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } wisard_state_e;

    // Ceiling log2, never narrower than one bit so counters always exist.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wisard_sample_buf.sv
// ============================================================================
// Module      : wisard_sample_buf
// Description : N_RAMS x ADDRESS_WIDTH sample store, one write port and one
//               combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wisard_sample_buf
    import wisard_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int N_RAMS        = 49,
    parameter int INDEX_WIDTH   = 6
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [INDEX_WIDTH-1:0]   wr_idx_i,
    input  logic [ADDRESS_WIDTH-1:0] wr_data_i,
    input  logic [INDEX_WIDTH-1:0]   rd_idx_i,
    output logic [ADDRESS_WIDTH-1:0] rd_data_o
);

    logic [ADDRESS_WIDTH-1:0] mem_q [N_RAMS];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/wisard_stream_tx.sv
// ============================================================================
// Module      : wisard_stream_tx
// Description : Buffers one sample of RAM addresses, streams it bit-serially
//               to a WiSARD classifier and holds the returned class.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wisard_stream_tx
    import wisard_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int INDEX_WIDTH   = 6,
    parameter int N_RAMS        = 49,
    parameter int CLASS_WIDTH   = 4,
    parameter int TIMEOUT       = 1023
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] in_data,
    output logic                     sop,
    output logic                     sink_valid,
    output logic                     addr,
    input  logic                     source_valid,
    input  logic [CLASS_WIDTH-1:0]   predicted_class,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [CLASS_WIDTH-1:0]   res_class,
    output logic                     res_err,
    output logic                     busy
);

    localparam int BW = clog2_min1(ADDRESS_WIDTH);
    localparam int TW = clog2_min1(TIMEOUT + 1);
    localparam logic [INDEX_WIDTH-1:0] C_LAST_WORD = INDEX_WIDTH'(N_RAMS - 1);
    localparam logic [BW-1:0]          C_LAST_BIT  = BW'(ADDRESS_WIDTH - 1);
    localparam logic [TW-1:0]          C_TIMEOUT   = TW'(TIMEOUT);

    wisard_state_e state_q, state_d;
    logic [INDEX_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic                   in_ready_q, in_ready_d;
    logic                   sop_q, sop_d;
    logic                   sink_valid_q, sink_valid_d;
    logic                   addr_q, addr_d;
    logic                   res_valid_q, res_valid_d;
    logic [CLASS_WIDTH-1:0] res_class_q, res_class_d;
    logic                   res_err_q, res_err_d;
    logic                   busy_q, busy_d;

    logic                     w_wr_en;
    logic                     w_last_bit;
    logic [BW-1:0]            w_next_bit;
    logic [INDEX_WIDTH-1:0]   w_next_word;
    logic [INDEX_WIDTH-1:0]   w_rd_idx;
    logic [ADDRESS_WIDTH-1:0] w_rd_word;
    logic                     w_first_bit;
    logic [TW-1:0]            w_tmo_inc;

    assign w_wr_en     = (state_q == ST_LOAD) && in_valid && in_ready_q;
    assign w_last_bit  = (word_cnt_q == C_LAST_WORD) && (bit_cnt_q == C_LAST_BIT);
    assign w_next_bit  = (bit_cnt_q == C_LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
    assign w_next_word = (bit_cnt_q == C_LAST_BIT) ? word_cnt_q + 1'b1 : word_cnt_q;
    assign w_rd_idx    = (state_q == ST_SEND && !w_last_bit) ? w_next_word : '0;
    assign w_tmo_inc   = tmo_cnt_q + 1'b1;
    // A one-word sample has RAM 0 arriving in the same cycle it must be sent.
    assign w_first_bit = (word_cnt_q == '0) ? in_data[0] : w_rd_word[0];

    wisard_sample_buf #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .N_RAMS        (N_RAMS),
        .INDEX_WIDTH   (INDEX_WIDTH)
    ) u_sample_buf (
        .clk       (clk),
        .wr_en_i   (w_wr_en),
        .wr_idx_i  (word_cnt_q),
        .wr_data_i (in_data),
        .rd_idx_i  (w_rd_idx),
        .rd_data_o (w_rd_word)
    );

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        in_ready_d   = in_ready_q;
        sop_d        = 1'b0;
        sink_valid_d = sink_valid_q;
        addr_d       = addr_q;
        res_valid_d  = res_valid_q;
        res_class_d  = res_class_q;
        res_err_d    = res_err_q;

        case (state_q)
            ST_LOAD: begin
                in_ready_d = 1'b1;
                if (w_wr_en) begin
                    if (word_cnt_q == C_LAST_WORD) begin
                        state_d      = ST_SEND;
                        in_ready_d   = 1'b0;
                        sop_d        = 1'b1;
                        sink_valid_d = 1'b1;
                        addr_d       = w_first_bit;
                        word_cnt_d   = '0;
                        bit_cnt_d    = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (w_last_bit) begin
                    state_d      = ST_WAIT;
                    sink_valid_d = 1'b0;
                    addr_d       = 1'b0;
                    tmo_cnt_d    = '0;
                end else begin
                    word_cnt_d = w_next_word;
                    bit_cnt_d  = w_next_bit;
                    addr_d     = w_rd_word[w_next_bit];
                end
            end
            ST_WAIT: begin
                // A result arriving on the timeout cycle still counts as valid.
                if (source_valid) begin
                    state_d     = ST_RESULT;
                    res_valid_d = 1'b1;
                    res_class_d = predicted_class;
                    res_err_d   = 1'b0;
                end else if (w_tmo_inc == C_TIMEOUT) begin
                    state_d     = ST_RESULT;
                    tmo_cnt_d   = w_tmo_inc;
                    res_valid_d = 1'b1;
                    res_class_d = '0;
                    res_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = w_tmo_inc;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d     = ST_LOAD;
                    res_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    word_cnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        busy_d = (state_d != ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            word_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            in_ready_q   <= 1'b0;
            sop_q        <= 1'b0;
            sink_valid_q <= 1'b0;
            addr_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_class_q  <= '0;
            res_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            in_ready_q   <= in_ready_d;
            sop_q        <= sop_d;
            sink_valid_q <= sink_valid_d;
            addr_q       <= addr_d;
            res_valid_q  <= res_valid_d;
            res_class_q  <= res_class_d;
            res_err_q    <= res_err_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign sop        = sop_q;
    assign sink_valid = sink_valid_q;
    assign addr       = addr_q;
    assign res_valid  = res_valid_q;
    assign res_class  = res_class_q;
    assign res_err    = res_err_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_wisard_stream_tx.sv
// ============================================================================
// Module      : tb_wisard_stream_tx
// Description : Directed self-checking bench for wisard_stream_tx (4-bit words,
//               3 RAMs, timeout of 10 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wisard_stream_tx;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       sop;
    logic       sink_valid;
    logic       addr;
    logic       source_valid;
    logic [3:0] predicted_class;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_class;
    logic       res_err;
    logic       busy;

    int total;
    int bad;

    wisard_stream_tx #(
        .ADDRESS_WIDTH (4),
        .INDEX_WIDTH   (6),
        .N_RAMS        (3),
        .CLASS_WIDTH   (4),
        .TIMEOUT       (10)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .sop             (sop),
        .sink_valid      (sink_valid),
        .addr            (addr),
        .source_valid    (source_valid),
        .predicted_class (predicted_class),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_class       (res_class),
        .res_err         (res_err),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic load3(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input bit toggle);
        logic [3:0] w [3];
        w[0] = a; w[1] = b; w[2] = c;
        for (int i = 0; i < 3; i++) begin
            if (toggle) begin
                in_valid = 1'b0;
                in_data  = 4'h6;
                @(negedge clk);
            end
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL load_in_ready word=%0d got=%b want=1", i, in_ready);
            end
            in_valid = 1'b1;
            in_data  = w[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 4'h0;
    endtask

    task automatic check_stream(input logic [11:0] exp, input bit noise, input string name);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (sink_valid !== 1'b1 || addr !== exp[i] || sop !== (i == 0)) begin
                bad++;
                $display("FAIL %s bit=%0d got sv=%b addr=%b sop=%b want sv=1 addr=%b sop=%b",
                         name, i, sink_valid, addr, sop, exp[i], (i == 0));
            end
            if (noise) begin
                source_valid    = (i % 2 == 0) && (i < 10);
                predicted_class = 4'h3;
                res_ready       = 1'b1;
            end
            @(negedge clk);
        end
        source_valid = 1'b0;
        total++;
        if (sink_valid !== 1'b0 || sop !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_end got sv=%b sop=%b busy=%b want sv=0 sop=0 busy=1",
                     name, sink_valid, sop, busy);
        end
    endtask

    task automatic finish_sample(input logic [3:0] cls);
        source_valid    = 1'b1;
        predicted_class = cls;
        @(negedge clk);
        source_valid = 1'b0;
        res_ready    = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || sop !== 1'b0 || sink_valid !== 1'b0 || addr !== 1'b0 ||
            res_valid !== 1'b0 || res_class !== 4'h0 || res_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got rdy=%b sop=%b sv=%b addr=%b rv=%b cls=%h err=%b busy=%b want all 0",
                     in_ready, sop, sink_valid, addr, res_valid, res_class, res_err, busy);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_ready got=%b want=0", in_ready);
        end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_cycle got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy);
        end
    endtask

    task automatic test_stream_result();
        load3(4'h1, 4'h8, 4'hF, 1'b0);
        check_stream(12'hF81, 1'b0, "stream_basic");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (res_valid !== 1'b0) begin
                bad++;
                $display("FAIL wait_no_result k=%0d got=%b want=0", k, res_valid);
            end
        end
        source_valid    = 1'b1;
        predicted_class = 4'h5;
        @(negedge clk);
        source_valid    = 1'b0;
        predicted_class = 4'h9;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (res_valid !== 1'b1 || res_class !== 4'h5 || res_err !== 1'b0 ||
                in_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL result_hold k=%0d got rv=%b cls=%h err=%b rdy=%b busy=%b want 1 5 0 0 1",
                         k, res_valid, res_class, res_err, in_ready, busy);
            end
            source_valid = (k == 1);
            @(negedge clk);
        end
        source_valid = 1'b0;
        total++;
        if (res_class !== 4'h5) begin
            bad++;
            $display("FAIL result_ignore_source got=%h want=5", res_class);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL handshake got rv=%b rdy=%b busy=%b want rv=0 rdy=1 busy=0",
                     res_valid, in_ready, busy);
        end
    endtask

    task automatic test_timeout();
        load3(4'h1, 4'h8, 4'hF, 1'b0);
        check_stream(12'hF81, 1'b0, "stream_timeout");
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k < 10) begin
                total++;
                if (res_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_early k=%0d got=%b want=0", k, res_valid);
                end
            end else begin
                total++;
                if (res_valid !== 1'b1 || res_class !== 4'h0 || res_err !== 1'b1) begin
                    bad++;
                    $display("FAIL timeout_result got rv=%b cls=%h err=%b want rv=1 cls=0 err=1",
                             res_valid, res_class, res_err);
                end
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_handshake got rv=%b rdy=%b want rv=0 rdy=1", res_valid, in_ready);
        end
    endtask

    task automatic test_toggle_load();
        load3(4'h1, 4'h8, 4'hF, 1'b1);
        check_stream(12'hF81, 1'b0, "stream_toggle");
        finish_sample(4'h2);
        total++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL toggle_return got rdy=%b rv=%b want rdy=1 rv=0", in_ready, res_valid);
        end
    endtask

    task automatic test_ignore_outside();
        load3(4'h1, 4'h8, 4'hF, 1'b0);
        check_stream(12'hF81, 1'b1, "stream_noise");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (res_valid !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL noise_no_capture k=%0d got rv=%b busy=%b want rv=0 busy=1",
                         k, res_valid, busy);
            end
        end
        source_valid    = 1'b1;
        predicted_class = 4'h7;
        @(negedge clk);
        source_valid = 1'b0;
        total++;
        if (res_valid !== 1'b1 || res_class !== 4'h7 || res_err !== 1'b0) begin
            bad++;
            $display("FAIL noise_capture got rv=%b cls=%h err=%b want rv=1 cls=7 err=0",
                     res_valid, res_class, res_err);
        end
        @(negedge clk);
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL noise_handshake got rv=%b rdy=%b want rv=0 rdy=1", res_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_send();
        load3(4'h1, 4'h8, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) @(negedge clk);
        total++;
        if (sink_valid !== 1'b1) begin
            bad++;
            $display("FAIL midsend_active got=%b want=1", sink_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (sink_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || addr !== 1'b0) begin
            bad++;
            $display("FAIL midsend_reset got sv=%b rdy=%b busy=%b addr=%b want all 0",
                     sink_valid, in_ready, busy, addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midsend_ready got=%b want=1", in_ready);
        end
        load3(4'h3, 4'hC, 4'h5, 1'b0);
        check_stream(12'h5C3, 1'b0, "stream_after_reset");
        finish_sample(4'h1);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst_n           = 1'b0;
        in_valid        = 1'b0;
        in_data         = 4'h0;
        source_valid    = 1'b0;
        predicted_class = 4'h0;
        res_ready       = 1'b0;

        test_reset();
        test_stream_result();
        test_timeout();
        test_toggle_load();
        test_ignore_outside();
        test_reset_mid_send();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
